// File: rtl/write_master_pkg.sv
// Shared types, default parameters and word-size helpers for the Avalon-MM write master.
package write_master_pkg;

    localparam int unsigned DEF_DATAWIDTH      = 32;
    localparam int unsigned DEF_ADDRESSWIDTH   = 32;
    localparam int unsigned DEF_FIFODEPTH      = 32;
    localparam int unsigned DEF_FIFODEPTH_LOG2 = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    function automatic int unsigned bytes_per_word(input int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned byte_lsbs(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/write_master_if.sv
// Avalon-MM write-direction bus between the write master and the interconnect.
interface write_master_if
    import write_master_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH = DEF_ADDRESSWIDTH,
    parameter int unsigned DATAWIDTH    = DEF_DATAWIDTH
);
    logic [ADDRESSWIDTH-1:0] master_address;
    logic                    master_write;
    logic [DATAWIDTH/8-1:0]  master_byteenable;
    logic [DATAWIDTH-1:0]    master_writedata;
    logic                    master_waitrequest;

    modport master (
        output master_address,
        output master_write,
        output master_byteenable,
        output master_writedata,
        input  master_waitrequest
    );

    modport slave (
        input  master_address,
        input  master_write,
        input  master_byteenable,
        input  master_writedata,
        output master_waitrequest
    );
endinterface

// File: rtl/write_master_fifo.sv
// Synchronous show-ahead FIFO; the head word is readable in the cycle after it is pushed.
module write_master_fifo
    import write_master_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_DATAWIDTH,
    parameter int unsigned DEPTH      = DEF_FIFODEPTH,
    parameter int unsigned DEPTH_LOG2 = DEF_FIFODEPTH_LOG2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned CW = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  push_ok;
    logic                  pop_ok;

    // Flags come from the registered count, so a same-cycle pop cannot rescue a push while full.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/write_master.sv
// Avalon-MM write master: drains a user-filled FIFO to an incrementing or fixed address.
// Optional beat counter output enabled by defining WRITE_MASTER_WORD_COUNT_EN.
module write_master
    import write_master_pkg::*;
#(
    parameter int unsigned DATAWIDTH      = DEF_DATAWIDTH,
    parameter int unsigned ADDRESSWIDTH   = DEF_ADDRESSWIDTH,
    parameter int unsigned FIFODEPTH      = DEF_FIFODEPTH,
    parameter int unsigned FIFODEPTH_LOG2 = DEF_FIFODEPTH_LOG2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0] control_write_base,
    input  logic [ADDRESSWIDTH-1:0] control_write_length,
    input  logic                    control_go,
    output logic                    control_done,
`ifdef WRITE_MASTER_WORD_COUNT_EN
    output logic [ADDRESSWIDTH-1:0] control_words_written,
`endif
    input  logic                    user_write_buffer,
    input  logic [DATAWIDTH-1:0]    user_buffer_data,
    output logic                    user_buffer_full,
    write_master_if.master          m_if
);
    localparam int unsigned BYTES      = bytes_per_word(DATAWIDTH);
    localparam int unsigned BYTE_LSBS  = byte_lsbs(DATAWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] ALIGN_MASK = ~ADDRESSWIDTH'(BYTES - 1);
    localparam logic [ADDRESSWIDTH-1:0] STEP       = ADDRESSWIDTH'(BYTES);

    state_e                  state_q;
    logic [ADDRESSWIDTH-1:0] addr_q;
    logic [ADDRESSWIDTH-1:0] len_q;
    logic                    fixed_q;

    logic                    fifo_empty;
    logic [DATAWIDTH-1:0]    fifo_head;
    logic                    len_ok;
    logic                    go_ok;
    logic                    beat;

    // Any set bit above the byte-select field means at least one whole word.
    assign len_ok = |control_write_length[ADDRESSWIDTH-1:BYTE_LSBS];
    assign go_ok  = control_go && len_ok && (state_q == IDLE);
    assign beat   = m_if.master_write && !m_if.master_waitrequest;

    assign control_done           = (state_q == IDLE);
    assign m_if.master_write      = (state_q == ACTIVE) && !fifo_empty;
    assign m_if.master_address    = addr_q;
    assign m_if.master_writedata  = fifo_head;
    assign m_if.master_byteenable = '1;

    write_master_fifo #(
        .WIDTH      (DATAWIDTH),
        .DEPTH      (FIFODEPTH),
        .DEPTH_LOG2 (FIFODEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (user_write_buffer),
        .data_i  (user_buffer_data),
        .pop_i   (beat),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (user_buffer_full)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            fixed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_ok) begin
                        addr_q  <= control_write_base & ALIGN_MASK;
                        len_q   <= control_write_length & ALIGN_MASK;
                        fixed_q <= control_fixed_location;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (beat) begin
                        len_q <= len_q - STEP;
                        if (!fixed_q) begin
                            addr_q <= addr_q + STEP;
                        end
                        if (len_q == STEP) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WRITE_MASTER_WORD_COUNT_EN
    logic [ADDRESSWIDTH-1:0] words_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            words_q <= '0;
        end else if (go_ok) begin
            words_q <= '0;
        end else if (beat) begin
            words_q <= words_q + ADDRESSWIDTH'(1);
        end
    end

    assign control_words_written = words_q;
`endif

endmodule

// File: tb/tb_write_master.sv
// Directed bench for write_master; also checks control_words_written when WRITE_MASTER_WORD_COUNT_EN is defined.
module tb_write_master;
    logic        clk = 1'b0;
    logic        rstn;
    logic        control_fixed_location;
    logic [31:0] control_write_base;
    logic [31:0] control_write_length;
    logic        control_go;
    logic        control_done;
    logic        user_write_buffer;
    logic [31:0] user_buffer_data;
    logic        user_buffer_full;
`ifdef WRITE_MASTER_WORD_COUNT_EN
    logic [31:0] control_words_written;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    write_master_if #(.ADDRESSWIDTH(32), .DATAWIDTH(32)) bus ();

    write_master dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .control_fixed_location (control_fixed_location),
        .control_write_base     (control_write_base),
        .control_write_length   (control_write_length),
        .control_go             (control_go),
        .control_done           (control_done),
`ifdef WRITE_MASTER_WORD_COUNT_EN
        .control_words_written  (control_words_written),
`endif
        .user_write_buffer      (user_write_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_buffer_full       (user_buffer_full),
        .m_if                   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            user_write_buffer = 1'b1;
            user_buffer_data  = first + 32'(i);
            tick();
        end
        user_write_buffer = 1'b0;
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] len, input logic fixed);
        control_go             = 1'b1;
        control_write_base     = base;
        control_write_length   = len;
        control_fixed_location = fixed;
        tick();
        control_go = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        control_fixed_location = 1'b0;
        control_write_base     = '0;
        control_write_length   = '0;
        control_go             = 1'b0;
        user_write_buffer      = 1'b0;
        user_buffer_data       = '0;
        bus.master_waitrequest = 1'b0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset state
        chk("rst_done", 64'(control_done), 64'd1);
        chk("rst_write", 64'(bus.master_write), 64'd0);
        chk("rst_addr", 64'(bus.master_address), 64'd0);
        chk("rst_wdata", 64'(bus.master_writedata), 64'd0);
        chk("rst_be", 64'(bus.master_byteenable), 64'hF);
        chk("rst_full", 64'(user_buffer_full), 64'd0);
        chk("rst_count", 64'(dut.u_fifo.count_q), 64'd0);
`ifdef WRITE_MASTER_WORD_COUNT_EN
        chk("rst_words", 64'(control_words_written), 64'd0);
`endif

        // Incrementing transfer, no stalls
        push_words(32'hA0, 4);
        chk("t1_idle_write", 64'(bus.master_write), 64'd0);
        chk("t1_count", 64'(dut.u_fifo.count_q), 64'd4);
        start(32'h1000, 32'd16, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_write", 64'(bus.master_write), 64'd1);
            chk("t1_addr", 64'(bus.master_address), 64'(32'h1000 + 32'(4 * i)));
            chk("t1_data", 64'(bus.master_writedata), 64'(32'hA0 + 32'(i)));
            chk("t1_busy", 64'(control_done), 64'd0);
            tick();
        end
        chk("t1_done", 64'(control_done), 64'd1);
        chk("t1_write_end", 64'(bus.master_write), 64'd0);
`ifdef WRITE_MASTER_WORD_COUNT_EN
        chk("t1_words", 64'(control_words_written), 64'd4);
`endif

        // Fixed address with two stall cycles per beat
        push_words(32'hB0, 4);
        start(32'h1000, 32'd16, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.master_waitrequest = 1'b1;
            for (int s = 0; s < 2; s++) begin
                chk("t2_stall_write", 64'(bus.master_write), 64'd1);
                chk("t2_stall_addr", 64'(bus.master_address), 64'h1000);
                chk("t2_stall_data", 64'(bus.master_writedata), 64'(32'hB0 + 32'(i)));
                tick();
            end
            bus.master_waitrequest = 1'b0;
            chk("t2_addr", 64'(bus.master_address), 64'h1000);
            chk("t2_data", 64'(bus.master_writedata), 64'(32'hB0 + 32'(i)));
            tick();
        end
        chk("t2_done", 64'(control_done), 64'd1);
        chk("t2_count", 64'(dut.u_fifo.count_q), 64'd0);

        // Start with empty FIFO, one word every 3 cycles
        start(32'h2000, 32'd16, 1'b0);
        chk("t3_empty_write", 64'(bus.master_write), 64'd0);
        chk("t3_busy", 64'(control_done), 64'd0);
        for (int i = 0; i < 4; i++) begin
            user_write_buffer = 1'b1;
            user_buffer_data  = 32'hC0 + 32'(i);
            tick();
            user_write_buffer = 1'b0;
            chk("t3_write", 64'(bus.master_write), 64'd1);
            chk("t3_addr", 64'(bus.master_address), 64'(32'h2000 + 32'(4 * i)));
            chk("t3_data", 64'(bus.master_writedata), 64'(32'hC0 + 32'(i)));
            tick();
            chk("t3_gap_write", 64'(bus.master_write), 64'd0);
            chk("t3_done", 64'(control_done), 64'(i == 3));
            if (i < 3) tick();
        end

        // Fill, overflow, and push+pop while full
        push_words(32'hD000, 32);
        chk("t4_full", 64'(user_buffer_full), 64'd1);
        push_words(32'hDEAD, 1);
        chk("t4_count_drop", 64'(dut.u_fifo.count_q), 64'd32);
        chk("t4_full_hold", 64'(user_buffer_full), 64'd1);
        start(32'h3000, 32'd128, 1'b0);
        chk("t4_write0", 64'(bus.master_write), 64'd1);
        chk("t4_data0", 64'(bus.master_writedata), 64'hD000);
        user_write_buffer = 1'b1;
        user_buffer_data  = 32'hBEEF;
        tick();
        user_write_buffer = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (i == 1) chk("t4_full_clr", 64'(user_buffer_full), 64'd0);
            chk("t4_write", 64'(bus.master_write), 64'd1);
            chk("t4_addr", 64'(bus.master_address), 64'(32'h3000 + 32'(4 * i)));
            chk("t4_data", 64'(bus.master_writedata), 64'(32'hD000 + 32'(i)));
            tick();
        end
        chk("t4_done", 64'(control_done), 64'd1);
        chk("t4_count_end", 64'(dut.u_fifo.count_q), 64'd0);
        chk("t4_write_end", 64'(bus.master_write), 64'd0);

        // Short length ignored, truncation/alignment, go while active ignored
        push_words(32'hE0, 2);
        start(32'h4000, 32'd3, 1'b0);
        chk("t5_short_done", 64'(control_done), 64'd1);
        chk("t5_short_write", 64'(bus.master_write), 64'd0);
        start(32'h5002, 32'd11, 1'b0);
        chk("t5_addr0", 64'(bus.master_address), 64'h5000);
        chk("t5_data0", 64'(bus.master_writedata), 64'hE0);
        start(32'h6000, 32'd64, 1'b1);
        chk("t5_write1", 64'(bus.master_write), 64'd1);
        chk("t5_addr1", 64'(bus.master_address), 64'h5004);
        chk("t5_data1", 64'(bus.master_writedata), 64'hE1);
        tick();
        chk("t5_done", 64'(control_done), 64'd1);
        chk("t5_write_end", 64'(bus.master_write), 64'd0);

        // Address wrap
        push_words(32'hF0, 2);
        start(32'hFFFF_FFFC, 32'd8, 1'b0);
        chk("t6_addr0", 64'(bus.master_address), 64'hFFFF_FFFC);
        chk("t6_data0", 64'(bus.master_writedata), 64'hF0);
        tick();
        chk("t6_addr1", 64'(bus.master_address), 64'h0);
        chk("t6_data1", 64'(bus.master_writedata), 64'hF1);
        tick();
        chk("t6_done", 64'(control_done), 64'd1);

        // Reset mid-transfer
        push_words(32'h70, 4);
        start(32'h7000, 32'd16, 1'b0);
        chk("t7_addr0", 64'(bus.master_address), 64'h7000);
        tick();
        chk("t7_addr1", 64'(bus.master_address), 64'h7004);
        tick();
        chk("t7_mid_write", 64'(bus.master_write), 64'd1);
        chk("t7_mid_busy", 64'(control_done), 64'd0);
`ifdef WRITE_MASTER_WORD_COUNT_EN
        chk("t7_words_mid", 64'(control_words_written), 64'd2);
`endif
        rstn = 1'b0;
        tick();
        chk("t7_rst_write", 64'(bus.master_write), 64'd0);
        chk("t7_rst_done", 64'(control_done), 64'd1);
        chk("t7_rst_count", 64'(dut.u_fifo.count_q), 64'd0);
        chk("t7_rst_addr", 64'(bus.master_address), 64'd0);
`ifdef WRITE_MASTER_WORD_COUNT_EN
        chk("t7_words_rst", 64'(control_words_written), 64'd0);
`endif
        rstn = 1'b1;
        tick();
        chk("t7_post_write", 64'(bus.master_write), 64'd0);
        chk("t7_post_done", 64'(control_done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
